// File: rtl/regfile_wb_if.sv
// Writeback arbiter bus: requester results, allocation, register-file
// write port and pending-destination scoreboard view.
interface regfile_wb_if #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
   logic [NUM_REQ*DATA_W-1:0] req_data_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic                      alloc_valid_i;
   logic [ADDR_W-1:0]         alloc_reg_i;
   logic                      wr_en_o;
   logic [ADDR_W-1:0]         wr_addr_o;
   logic [DATA_W-1:0]         wr_data_o;
   logic [(1<<ADDR_W)-1:0]    pending_o;
   logic                      alloc_conflict_o;

   modport master (
      output req_valid_i, req_addr_i, req_data_i,
      output alloc_valid_i, alloc_reg_i,
      input  req_ready_o, wr_en_o, wr_addr_o, wr_data_o,
      input  pending_o, alloc_conflict_o
   );

   modport slave (
      input  req_valid_i, req_addr_i, req_data_i,
      input  alloc_valid_i, alloc_reg_i,
      output req_ready_o, wr_en_o, wr_addr_o, wr_data_o,
      output pending_o, alloc_conflict_o
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the FPU register-file write port,
// with a registered write stage and a pending-destination scoreboard.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input logic         clk,
   input logic         reset,
   regfile_wb_if.slave bus
);
   localparam int NREG  = 1 << ADDR_W;
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);
   localparam logic [PTR_W:0]   NUMW = (PTR_W+1)'(NUM_REQ);

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   gnt_idx;
   logic [PTR_W-1:0]   ptr_nxt;
   logic [PTR_W:0]     cand;
   logic [NUM_REQ-1:0] grant;
   logic               xfer;
   logic [ADDR_W-1:0]  gnt_addr;
   logic [DATA_W-1:0]  gnt_data;

   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [DATA_W-1:0]  wr_data;
   logic [NREG-1:0]    pending;
   logic [NREG-1:0]    pend_nxt;
   logic               conflict;
   logic               conflict_nxt;

   // Walk requesters starting at rr_ptr, wrapping once.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      xfer    = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (cand >= NUMW)
            cand = cand - NUMW;
         if (!xfer && bus.req_valid_i[cand[PTR_W-1:0]]) begin
            xfer                     = 1'b1;
            gnt_idx                  = cand[PTR_W-1:0];
            grant[cand[PTR_W-1:0]]   = 1'b1;
         end
      end
      if (reset) begin
         grant = '0;
         xfer  = 1'b0;
      end
   end

   always_comb begin
      gnt_addr = '0;
      gnt_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            gnt_addr = bus.req_addr_i[i*ADDR_W +: ADDR_W];
            gnt_data = bus.req_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign ptr_nxt = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;

   // Clear applies first so a same-edge allocation re-marks the register.
   always_comb begin
      pend_nxt     = pending;
      conflict_nxt = 1'b0;
      if (wr_en)
         pend_nxt[wr_addr] = 1'b0;
      if (bus.alloc_valid_i) begin
         pend_nxt[bus.alloc_reg_i] = 1'b1;
         conflict_nxt = pending[bus.alloc_reg_i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr   <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         pending  <= '0;
         conflict <= 1'b0;
      end else begin
         wr_en    <= xfer;
         pending  <= pend_nxt;
         conflict <= conflict_nxt;
         if (xfer) begin
            rr_ptr  <= ptr_nxt;
            wr_addr <= gnt_addr;
            wr_data <= gnt_data;
         end
      end
   end

   assign bus.req_ready_o      = grant;
   assign bus.wr_en_o          = wr_en;
   assign bus.wr_addr_o        = wr_addr;
   assign bus.wr_data_o        = wr_data;
   assign bus.pending_o        = pending;
   assign bus.alloc_conflict_o = conflict;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a
// transaction-level reference model.
module tb_regfile_wb_arbiter;
   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_wb_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

   regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Register file fed by the write port
   logic [DW-1:0] rf [32];
   always @(posedge clk)
      if (bus.wr_en_o) rf[bus.wr_addr_o] <= bus.wr_data_o;

   int          m_ptr;
   bit          m_en;
   int          m_addr;
   logic [31:0] m_data;
   logic [31:0] m_pend;
   bit          m_conf;
   int          last_g;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic setreq(int i, bit v, int a, logic [DW-1:0] d);
      bus.req_valid_i[i]         = v;
      bus.req_addr_i[i*AW +: AW] = AW'(a);
      bus.req_data_i[i*DW +: DW] = d;
   endtask

   task automatic alloc(bit v, int r);
      bus.alloc_valid_i = v;
      bus.alloc_reg_i   = AW'(r);
   endtask

   // One clock: check ready, step model at posedge, check registered outputs.
   task automatic cyc(string tag);
      int          g;
      logic [N-1:0] er;
      logic [31:0] np;
      #1;
      g  = reset ? -1 : pick(bus.req_valid_i);
      er = (g < 0) ? '0 : N'(1 << g);
      chk({tag, ".ready"}, 64'(bus.req_ready_o), 64'(er));
      @(posedge clk);
      if (reset) begin
         m_ptr = 0; m_en = 0; m_addr = 0;
         m_data = 0; m_pend = 0; m_conf = 0;
      end else begin
         np = m_pend;
         if (m_en) np[m_addr] = 1'b0;
         m_conf = 0;
         if (bus.alloc_valid_i) begin
            m_conf = m_pend[bus.alloc_reg_i];
            np[bus.alloc_reg_i] = 1'b1;
         end
         m_pend = np;
         if (g >= 0) begin
            m_en   = 1;
            m_addr = int'(bus.req_addr_i[g*AW +: AW]);
            m_data = bus.req_data_i[g*DW +: DW];
            m_ptr  = (g + 1) % N;
         end else begin
            m_en = 0;
         end
      end
      last_g = g;
      #1;
      chk({tag, ".wr_en"}, 64'(bus.wr_en_o), 64'(m_en));
      chk({tag, ".wr_addr"}, 64'(bus.wr_addr_o), 64'(m_addr));
      chk({tag, ".wr_data"}, 64'(bus.wr_data_o), 64'(m_data));
      chk({tag, ".pending"}, 64'(bus.pending_o), 64'(m_pend));
      chk({tag, ".conflict"}, 64'(bus.alloc_conflict_o), 64'(m_conf));
      @(negedge clk);
   endtask

   task automatic idle();
      for (int i = 0; i < N; i++) setreq(i, 0, 0, 0);
      alloc(0, 0);
   endtask

   initial begin
      logic [N-1:0] busy;
      reset = 1'b1;
      m_ptr = 0; m_en = 0; m_addr = 0; m_data = 0; m_pend = 0; m_conf = 0;
      idle();
      @(negedge clk);

      // 1: reset with all requesters valid
      for (int i = 0; i < N; i++) setreq(i, 1, 20 + i, 100 + i);
      cyc("rst0");
      cyc("rst1");
      chk("rst.wr_en", 64'(bus.wr_en_o), 64'(0));
      chk("rst.pending", 64'(bus.pending_o), 64'(0));
      reset = 1'b0;
      cyc("rel");
      chk("rel.first", 64'(last_g), 64'(0));
      idle();
      cyc("idle");

      // 2: single writes to r0 and r1
      alloc(1, 0);
      cyc("a0");
      alloc(0, 0);
      setreq(0, 1, 0, 12);
      cyc("w0");
      chk("w0.gnt", 64'(last_g), 64'(0));
      chk("w0.en", 64'(bus.wr_en_o), 64'(1));
      chk("w0.data", 64'(bus.wr_data_o), 64'(12));
      idle();
      cyc("w0c");
      chk("w0.clr", 64'(bus.pending_o[0]), 64'(0));
      alloc(1, 1);
      cyc("a1");
      alloc(0, 0);
      setreq(1, 1, 1, 16);
      cyc("w1");
      chk("w1.gnt", 64'(last_g), 64'(1));
      idle();
      cyc("w1c");
      chk("w1.clr", 64'(bus.pending_o[1]), 64'(0));
      chk("rf.r0", 64'(rf[0]), 64'(12));
      chk("rf.r1", 64'(rf[1]), 64'(16));

      // 3: round robin from a fresh pointer
      reset = 1'b1;
      cyc("rst2");
      reset = 1'b0;
      for (int i = 0; i < N; i++) setreq(i, 1, 10 + i, $urandom);
      for (int j = 0; j < 6; j++) begin
         cyc("rr");
         chk("rr.order", 64'(last_g), 64'(j % N));
         chk("rr.en", 64'(bus.wr_en_o), 64'(1));
         setreq(last_g, 1, 10 + last_g, $urandom);
      end

      // 4: wrap and skip
      idle();
      setreq(1, 1, 4, $urandom);
      cyc("p2");
      chk("p2.gnt", 64'(last_g), 64'(1));
      setreq(1, 1, 4, $urandom);
      cyc("skip");
      chk("skip.gnt", 64'(last_g), 64'(1));
      setreq(1, 0, 0, 0);
      setreq(0, 1, 6, $urandom);
      setreq(2, 1, 8, $urandom);
      cyc("wrap");
      chk("wrap.gnt", 64'(last_g), 64'(2));
      setreq(2, 0, 0, 0);
      cyc("wrap2");
      chk("wrap2.gnt", 64'(last_g), 64'(0));
      idle();
      cyc("idle2");

      // 5: scoreboard collisions
      alloc(1, 5);
      cyc("a5");
      alloc(0, 0);
      setreq(0, 1, 5, $urandom);
      cyc("w5");
      setreq(0, 0, 0, 0);
      alloc(1, 5);
      cyc("c5");
      chk("c5.pend", 64'(bus.pending_o[5]), 64'(1));
      chk("c5.conf", 64'(bus.alloc_conflict_o), 64'(1));
      alloc(0, 0);
      cyc("c5b");
      chk("c5b.conf", 64'(bus.alloc_conflict_o), 64'(0));
      alloc(1, 3);
      cyc("a3");
      alloc(0, 0);
      setreq(1, 1, 3, $urandom);
      cyc("w3");
      setreq(1, 0, 0, 0);
      alloc(1, 7);
      cyc("c7");
      chk("c7.p7", 64'(bus.pending_o[7]), 64'(1));
      chk("c7.p3", 64'(bus.pending_o[3]), 64'(0));
      chk("c7.conf", 64'(bus.alloc_conflict_o), 64'(0));
      alloc(0, 0);

      // 6: reset while a write is registered
      alloc(1, 9);
      cyc("a9");
      alloc(0, 0);
      setreq(2, 1, 9, $urandom);
      cyc("w9");
      chk("w9.gnt", 64'(last_g), 64'(2));
      setreq(2, 0, 0, 0);
      reset = 1'b1;
      cyc("rst3");
      chk("rst3.en", 64'(bus.wr_en_o), 64'(0));
      chk("rst3.pend", 64'(bus.pending_o), 64'(0));
      reset = 1'b0;
      for (int i = 0; i < N; i++) setreq(i, 1, i, $urandom);
      cyc("rst3p");
      chk("rst3.ptr", 64'(last_g), 64'(0));
      idle();

      // Random traffic; requests hold until granted
      busy = '0;
      for (int t = 0; t < 300; t++) begin
         for (int i = 0; i < N; i++)
            if (!busy[i] && ($urandom_range(0, 99) < 60)) begin
               busy[i] = 1'b1;
               setreq(i, 1, $urandom_range(0, 31), $urandom);
            end
         alloc($urandom_range(0, 99) < 30, $urandom_range(0, 31));
         cyc("rnd");
         if (last_g >= 0) begin
            busy[last_g] = 1'b0;
            setreq(last_g, 0, 0, 0);
         end
      end
      idle();
      cyc("end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 FPU register file.
- Round-robin arbitrates writeback requests from NUM_REQ pipeline units (FP add, FP mul, load) onto that port, with one registered output stage.
- Keeps a pending-destination scoreboard so issue logic can stall on RAW hazards against in-flight results.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- ADDR_W, 5, register address width (2^ADDR_W registers).
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  requester i has a result.
- req_addr_i  in  NUM_REQ*ADDR_W  destination of requester i, slice [i*ADDR_W +: ADDR_W].
- req_data_i  in  NUM_REQ*DATA_W  result of requester i, slice [i*DATA_W +: DATA_W].
- req_ready_o  out  NUM_REQ  one-hot grant, combinational.
- alloc_valid_i  in  1  issue stage dispatches an instruction with a destination.
- alloc_reg_i  in  ADDR_W  destination register being allocated.
- wr_en_o  out  1  register-file write enable.
- wr_addr_o  out  ADDR_W  register-file write address.
- wr_data_o  out  DATA_W  register-file write data.
- pending_o  out  2^ADDR_W  bit r = 1 while register r awaits writeback.
- alloc_conflict_o  out  1  one-cycle pulse on allocation to an already-pending register.

Behaviour:
- Reset:
  - rr_ptr=0; wr_en_o=0; wr_addr_o=0; wr_data_o=0; pending_o=0; alloc_conflict_o=0.
  - While reset is high, req_ready_o=0.
  - Reset mid-transfer drops any registered write: no write is issued the cycle after reset.
- Arbitration (combinational):
  - Search starts at index rr_ptr and wraps modulo NUM_REQ.
  - The first i with req_valid_i[i]=1 gets req_ready_o[i]=1; all other ready bits are 0.
  - No valid requests gives req_ready_o=0.
  - A transfer occurs on a posedge with req_valid_i[i] & req_ready_o[i].
  - Requesters hold valid, addr and data stable until granted.
- Pointer update:
  - On a transfer from i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
- Output stage (latency 1):
  - On a transfer, wr_en_o<=1, wr_addr_o<=granted addr, wr_data_o<=granted data.
  - Otherwise wr_en_o<=0, and wr_addr_o/wr_data_o hold their last value.
  - The register file commits on the posedge while wr_en_o=1, so data is written 2 edges after the grant cycle begins.
  - The port accepts one write per cycle, giving back-to-back grants and full throughput.
- Scoreboard:
  - Set: alloc_valid_i=1 sets pending[alloc_reg_i] on the posedge.
  - Clear: wr_en_o=1 at a posedge clears pending[wr_addr_o], i.e. on the same edge the register file commits.
  - pending[r] therefore falls the cycle the new value is readable.
  - Set and clear of the same register on the same edge: set wins, bit stays 1 (new producer).
  - Set and clear of different registers on the same edge: both take effect.
  - Allocation to a register whose pending bit is already 1 (before this edge's clear): alloc_conflict_o<=1 for one cycle and the bit remains 1. Otherwise alloc_conflict_o<=0.
  - No counting: one in-flight producer per register is the design contract, and the conflict flag reports violations.
- Register 0 is an ordinary writable register with no special casing.
- Write without a prior allocation: the write proceeds, and the clear of an already-0 bit has no effect.

Test Plan:
1. Reset then idle: assert reset 2 cycles with all req_valid_i high → req_ready_o=0, wr_en_o=0, pending_o=0. Release reset → grant goes to requester 0 first.
2. Single write: alloc r0; next cycle req0 valid addr=0 data=12 → ready0=1 that cycle; next cycle wr_en_o=1, addr 0, data 12; the cycle after that pending_o[0]=0. Repeat for r1/16, then read r0=12 and r1=16 through the register file.
3. Round-robin fairness: all 3 requesters continuously valid → grant order 0,1,2,0,1,2 with wr_en_o high every cycle and data matching each grant one cycle later.
4. Wrap and skip: rr_ptr=2, only req1 valid → req1 granted and rr_ptr becomes 2. Next cycle req0 and req2 valid → req2 granted, then req0.
5. Scoreboard collisions:
   - Alloc r5 on the same edge that wr_en_o commits r5 → pending_o[5] stays 1, alloc_conflict_o=1 one cycle.
   - Alloc r7 while r3 commits → pending_o[7]=1, pending_o[3]=0, no conflict.
6. Reset mid-operation: grant req2 (addr 9) and assert reset in the following cycle → wr_en_o=0 after reset, pending_o=0, rr_ptr=0.
